// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN spike encoder/decoder pair.
//   sample_t     : signed 32-bit ECG sample
//   SAMPLE_MAX/MIN: clamp limits of sample_t
//   sat_add()    : saturating add of a 34-bit signed step to a sample
//   spike_dir_e  : decoded spike direction of one clock cycle
package snn_pkg;

  typedef logic signed [31:0] sample_t;

  localparam sample_t SAMPLE_MAX = 32'sh7FFF_FFFF;
  localparam sample_t SAMPLE_MIN = 32'sh8000_0000;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    BOTH = 2'd3
  } spike_dir_e;

  // The sum is formed at 34 bits so that neither a full 32-bit unsigned
  // step nor its negation can wrap before the clamp is applied.
  function automatic sample_t sat_add(sample_t a, logic signed [33:0] b);
    logic signed [33:0] a_ext;
    logic signed [33:0] sum;
    logic signed [33:0] max_ext;
    logic signed [33:0] min_ext;
    a_ext   = {{2{a[31]}}, a};
    max_ext = {2'b00, SAMPLE_MAX};
    min_ext = {2'b11, SAMPLE_MIN};
    sum     = a_ext + b;
    if (sum > max_ext) begin
      return SAMPLE_MAX;
    end else if (sum < min_ext) begin
      return SAMPLE_MIN;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/sample_tick.sv
// Sample-window tick generator, shared by the spike encoder and decoder.
//   clk_i  : system clock
//   rst_i  : asynchronous active-low reset
//   tick_o : high for one cycle, on the last cycle of every CLK_DIV window
module sample_tick #(
  parameter int unsigned CLK_DIV = 1200000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  assign tick_o    = (div_cnt_q == DIV_LAST);
  assign div_cnt_d = tick_o ? '0 : div_cnt_q + 1'b1;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/spike_decoder.sv
// Reconstructs a signed ECG sample stream from an up/down spike train.
// Each spike adds/subtracts the window's latched delta (saturating); at
// every window boundary the sample and the window's spike counts are
// offered on a valid/ready output.
//   clk_i, rst_i           : clock, asynchronous active-low reset
//   up_spike_i, dn_spike_i : one-cycle spike pulses
//   delta_i                : unsigned step, latched at each window start
//   ecg_o, up_cnt_o, dn_cnt_o, valid_o / ready_i : sample output handshake
//   conflict_o             : pulse, both spikes seen in one cycle
//   overrun_o              : sticky, a window sample was dropped
module spike_decoder
  import snn_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 1200000,
  parameter sample_t     INIT_VALUE = '0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             up_spike_i,
  input  logic             dn_spike_i,
  input  logic [31:0]      delta_i,
  output logic [31:0]      ecg_o,
  output logic [CNT_W-1:0] up_cnt_o,
  output logic [CNT_W-1:0] dn_cnt_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             conflict_o,
  output logic             overrun_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic tick;

  sample_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  sample_t          recon_q, recon_d;
  logic [CNT_W-1:0] up_q, up_d;
  logic [CNT_W-1:0] dn_q, dn_d;
  logic [31:0]      delta_r_q;
  logic             first_q;
  logic             conflict_d;
  logic [31:0]      delta_eff;
  logic signed [33:0] step;
  spike_dir_e       dir;

  // The first clock after reset opens a window, so it uses delta_i directly
  // while delta_r is being loaded.
  assign delta_eff = first_q ? delta_i : delta_r_q;
  assign step      = {2'b00, delta_eff};
  assign dir       = spike_dir_e'({dn_spike_i, up_spike_i});

  // NOTE: every always_comb output is defaulted first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    recon_d    = recon_q;
    up_d       = up_q;
    dn_d       = dn_q;
    conflict_d = 1'b0;
    unique case (dir)
      UP: begin
        recon_d = sat_add(recon_q, step);
        if (up_q != CNT_MAX) up_d = up_q + 1'b1;
      end
      DOWN: begin
        recon_d = sat_add(recon_q, -step);
        if (dn_q != CNT_MAX) dn_d = dn_q + 1'b1;
      end
      BOTH:    conflict_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      recon_q    <= INIT_VALUE;
      up_q       <= '0;
      dn_q       <= '0;
      delta_r_q  <= '0;
      first_q    <= 1'b1;
      ecg_o      <= '0;
      up_cnt_o   <= '0;
      dn_cnt_o   <= '0;
      valid_o    <= 1'b0;
      conflict_o <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      first_q    <= 1'b0;
      recon_q    <= recon_d;
      conflict_o <= conflict_d;
      // Tick-cycle spikes are already folded into up_d/dn_d/recon_d, so the
      // snapshot below includes them before the counters restart.
      up_q       <= tick ? '0 : up_d;
      dn_q       <= tick ? '0 : dn_d;
      if (first_q || tick) delta_r_q <= delta_i;

      if (tick) begin
        if (!valid_o || ready_i) begin
          ecg_o    <= recon_d;
          up_cnt_o <= up_d;
          dn_cnt_o <= dn_d;
          valid_o  <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_decoder.sv
// Directed bench for spike_decoder with CLK_DIV=4. A main instance
// (INIT_VALUE=100) covers reconstruction, conflict, backpressure, delta
// change and reset; two extra instances cover positive/negative clamping.
module tb_spike_decoder;
  import snn_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic up_a, dn_a, ready_a;
  logic [31:0] delta_a;
  logic [31:0] ecg_a;
  logic [7:0]  upc_a, dnc_a;
  logic valid_a, conflict_a, overrun_a;

  logic up_hi, dn_lo;
  logic [31:0] ecg_hi, ecg_lo;
  logic [7:0]  upc_hi, dnc_hi, upc_lo, dnc_lo;
  logic valid_hi, conflict_hi, overrun_hi;
  logic valid_lo, conflict_lo, overrun_lo;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  spike_decoder #(.CLK_DIV(4), .INIT_VALUE(32'sd100), .CNT_W(8)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .up_spike_i(up_a), .dn_spike_i(dn_a),
    .delta_i(delta_a), .ecg_o(ecg_a), .up_cnt_o(upc_a), .dn_cnt_o(dnc_a),
    .valid_o(valid_a), .ready_i(ready_a), .conflict_o(conflict_a),
    .overrun_o(overrun_a)
  );

  spike_decoder #(.CLK_DIV(4), .INIT_VALUE(32'sh7FFF_FFF0), .CNT_W(8)) u_hi (
    .clk_i(clk), .rst_i(rst_n), .up_spike_i(up_hi), .dn_spike_i(1'b0),
    .delta_i(32'h20), .ecg_o(ecg_hi), .up_cnt_o(upc_hi), .dn_cnt_o(dnc_hi),
    .valid_o(valid_hi), .ready_i(1'b1), .conflict_o(conflict_hi),
    .overrun_o(overrun_hi)
  );

  spike_decoder #(.CLK_DIV(4), .INIT_VALUE(-32'sd2147483643), .CNT_W(8)) u_lo (
    .clk_i(clk), .rst_i(rst_n), .up_spike_i(1'b0), .dn_spike_i(dn_lo),
    .delta_i(32'h20), .ecg_o(ecg_lo), .up_cnt_o(upc_lo), .dn_cnt_o(dnc_lo),
    .valid_o(valid_lo), .ready_i(1'b1), .conflict_o(conflict_lo),
    .overrun_o(overrun_lo)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; up_a = 1'b0; dn_a = 1'b0; ready_a = 1'b1;
    delta_a = 32'd10; up_hi = 1'b0; dn_lo = 1'b0;
    #12;
    check("rst_ecg",      ecg_a, 32'd0);
    check("rst_valid",    32'(valid_a), 32'd0);
    check("rst_cnts",     {upc_a, dnc_a}, 32'd0);
    check("rst_flags",    {conflict_a, overrun_a}, 32'd0);

    // Window 1 (edges 1..4): three up spikes with delta 10 from edge 1.
    @(negedge clk);
    rst_n = 1'b1;
    up_a  = 1'b1;
    step();                               // e1: 110
    up_hi = 1'b1; dn_lo = 1'b1;
    step();                               // e2: 120, clamps
    up_hi = 1'b0; dn_lo = 1'b0;
    step();                               // e3: 130
    check("pre_tick_valid", 32'(valid_a), 32'd0);
    up_a = 1'b0;
    step();                               // e4: tick
    check("w1_valid", 32'(valid_a), 32'd1);
    check("w1_ecg",   ecg_a, 32'd130);
    check("w1_upcnt", 32'(upc_a), 32'd3);
    check("w1_dncnt", 32'(dnc_a), 32'd0);
    check("sat_hi_ecg", ecg_hi, 32'h7FFF_FFFF);
    check("sat_hi_up",  32'(upc_hi), 32'd1);
    check("sat_lo_ecg", ecg_lo, 32'h8000_0000);
    check("sat_lo_dn",  32'(dnc_lo), 32'd1);

    // Window 2 (edges 5..8): conflict, then one down spike.
    up_a = 1'b1; dn_a = 1'b1;
    step();                               // e5
    check("w1_valid_one_cycle", 32'(valid_a), 32'd0);
    check("conflict_hi", 32'(conflict_a), 32'd1);
    up_a = 1'b0;
    step();                               // e6: 120
    check("conflict_lo", 32'(conflict_a), 32'd0);
    dn_a = 1'b0;
    step();                               // e7
    step();                               // e8: tick
    check("w2_ecg",   ecg_a, 32'd120);
    check("w2_upcnt", 32'(upc_a), 32'd0);
    check("w2_dncnt", 32'(dnc_a), 32'd1);

    // Window 3 (edges 9..12): backpressure across the next tick.
    ready_a = 1'b0;
    step();                               // e9
    up_a = 1'b1;
    step();                               // e10: recon 130
    up_a = 1'b0;
    step();                               // e11
    check("no_overrun_yet", 32'(overrun_a), 32'd0);
    step();                               // e12: tick, sample dropped
    check("bp_valid",   32'(valid_a), 32'd1);
    check("bp_held",    ecg_a, 32'd120);
    check("bp_held_dn", 32'(dnc_a), 32'd1);
    check("bp_overrun", 32'(overrun_a), 32'd1);
    ready_a = 1'b1;
    step();                               // e13: transfer
    check("bp_released", 32'(valid_a), 32'd0);
    check("overrun_sticky", 32'(overrun_a), 32'd1);

    // Window 4 (edges 13..16): delta changes mid-window, tick-cycle spike.
    delta_a = 32'd50;
    step();                               // e14
    step();                               // e15
    up_a = 1'b1;
    step();                               // e16: tick, +10 -> 140
    check("w4_ecg",   ecg_a, 32'd140);
    check("w4_upcnt", 32'(upc_a), 32'd1);
    step();                               // e17: +50 -> 190
    up_a = 1'b0;
    step();                               // e18
    step();                               // e19
    step();                               // e20: tick
    check("w5_ecg",   ecg_a, 32'd190);
    check("w5_upcnt", 32'(upc_a), 32'd1);

    // Reset mid-window while a sample is pending.
    ready_a = 1'b0;
    up_a    = 1'b1;
    step();                               // e21: recon 240
    up_a = 1'b0;
    check("pre_reset_valid", 32'(valid_a), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ecg",   ecg_a, 32'd0);
    check("async_rst_valid", 32'(valid_a), 32'd0);
    check("async_rst_cnts",  {upc_a, dnc_a}, 32'd0);
    check("async_rst_flags", {conflict_a, overrun_a}, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    ready_a = 1'b1;
    step();                               // r1
    step();                               // r2
    step();                               // r3
    check("post_rst_no_pending", 32'(valid_a), 32'd0);
    step();                               // r4: tick
    check("post_rst_valid", 32'(valid_a), 32'd1);
    check("post_rst_ecg",   ecg_a, 32'd100);
    check("post_rst_cnts",  {upc_a, dnc_a}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
